// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing generator.
//   - Default panel timing (480x272 class panel, porches/syncs in pixel clocks / lines).
//   - Scan FSM state encoding.
package lcd_pkg;

  localparam int unsigned LCD_H_ACTIVE = 480;
  localparam int unsigned LCD_H_FRONT  = 8;
  localparam int unsigned LCD_H_SYNC   = 4;
  localparam int unsigned LCD_H_BACK   = 43;

  localparam int unsigned LCD_V_ACTIVE = 272;
  localparam int unsigned LCD_V_FRONT  = 8;
  localparam int unsigned LCD_V_SYNC   = 4;
  localparam int unsigned LCD_V_BACK   = 12;

  localparam int unsigned LCD_SETTLE_CYCLES = 1024;
  localparam int unsigned LCD_RGB_W         = 16;

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StSettle   = 2'd1,
    StRun      = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_timing_if.sv
// Pixel fetch bus and panel bus of the LCD timing generator.
//   fetch_valid/fetch_x/fetch_y : pixel request to the frame source
//   pixel_data                  : source reply, one cycle after fetch_valid
//   lcd_hsync/lcd_vsync/lcd_de/lcd_rgb : panel timing and pixel bus
// master = timing generator, slave = source/panel side.
interface lcd_timing_if
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE = LCD_H_ACTIVE,
  parameter int unsigned V_ACTIVE = LCD_V_ACTIVE,
  parameter int unsigned RGB_W    = LCD_RGB_W
);
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);

  logic             fetch_valid;
  logic [XW-1:0]    fetch_x;
  logic [YW-1:0]    fetch_y;
  logic [RGB_W-1:0] pixel_data;
  logic             lcd_hsync;
  logic             lcd_vsync;
  logic             lcd_de;
  logic [RGB_W-1:0] lcd_rgb;

  modport master (
    output fetch_valid, fetch_x, fetch_y,
    input  pixel_data,
    output lcd_hsync, lcd_vsync, lcd_de, lcd_rgb
  );

  modport slave (
    input  fetch_valid, fetch_x, fetch_y,
    output pixel_data,
    input  lcd_hsync, lcd_vsync, lcd_de, lcd_rgb
  );

endinterface

// File: rtl/lock_sync.sv
// PLL lock synchronizer and settle counter.
//   clock, reset_n : pixel clock, async active-low reset
//   locked         : raw PLL lock (asynchronous)
//   lock_s         : locked after a 2-flop synchronizer
//   lock_ok        : lock_s has been high for SETTLE_CYCLES consecutive cycles
module lock_sync #(
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset_n,
  input  logic locked,
  output logic lock_s,
  output logic lock_ok
);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q = number of consecutive lock_s cycles seen before this one; any low sample clears it.
  always_comb begin
    cnt_d = '0;
    if (sync_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= locked;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
    end
  end

  assign lock_s  = sync_q;
  assign lock_ok = sync_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/lcd_timing.sv
// LCD raster timing generator.
//   clock, reset_n : pixel clock, async active-low reset
//   locked         : PLL lock; scanning starts once it has been stable for SETTLE_CYCLES
//   bus            : fetch request / pixel reply and panel outputs (lcd_timing_if.master)
//   frame_start    : one-cycle pulse with the fetch of pixel (0,0)
//   running        : high while scanning
// Pipeline: counters -> fetch regs (stage 0) -> stage 1 (pixel_data arrives) -> panel regs.
module lcd_timing
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = LCD_H_ACTIVE,
  parameter int unsigned H_FRONT         = LCD_H_FRONT,
  parameter int unsigned H_SYNC          = LCD_H_SYNC,
  parameter int unsigned H_BACK          = LCD_H_BACK,
  parameter int unsigned V_ACTIVE        = LCD_V_ACTIVE,
  parameter int unsigned V_FRONT         = LCD_V_FRONT,
  parameter int unsigned V_SYNC          = LCD_V_SYNC,
  parameter int unsigned V_BACK          = LCD_V_BACK,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE_CYCLES   = LCD_SETTLE_CYCLES,
  parameter int unsigned RGB_W           = LCD_RGB_W
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        locked,
  lcd_timing_if.master bus,
  output logic        frame_start,
  output logic        running
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned XW      = $clog2(H_ACTIVE);
  localparam int unsigned YW      = $clog2(V_ACTIVE);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;

  lcd_state_e state_q, state_d;
  logic       lock_s, lock_ok;

  lock_sync #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_lock_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .locked (locked),
    .lock_s (lock_s),
    .lock_ok(lock_ok)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lock_s) state_d = StSettle;
      StSettle: begin
        if (!lock_s)      state_d = StWaitLock;
        else if (lock_ok) state_d = StRun;
      end
      StRun:      if (!lock_s) state_d = StWaitLock;
      default:    state_d = StWaitLock;
    endcase
  end

  // scan is low on the RUN entry cycle and on the exit cycle, so counters start at 0,0 and
  // every pipeline slot is flushed the moment RUN is left.
  logic in_run, scan;
  assign in_run = (state_q == StRun);
  assign scan   = in_run && (state_d == StRun);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (scan) begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
      end
    end
  end

  logic h_act, v_act, h_sync_win, v_sync_win;
  assign h_act      = h_cnt_q < HW'(H_ACTIVE);
  assign v_act      = v_cnt_q < VW'(V_ACTIVE);
  assign h_sync_win = (h_cnt_q >= HW'(HS_BEG)) && (h_cnt_q < HW'(HS_BEG + H_SYNC));
  assign v_sync_win = (v_cnt_q >= VW'(VS_BEG)) && (v_cnt_q < VW'(VS_BEG + V_SYNC));

  // Syncs are carried active-high internally and converted to panel polarity at the pins.
  logic             fetch_valid_q, frame_start_q;
  logic [XW-1:0]    fetch_x_q;
  logic [YW-1:0]    fetch_y_q;
  logic             hs0_q, vs0_q, de1_q, hs1_q, vs1_q, de2_q, hs2_q, vs2_q;
  logic [RGB_W-1:0] rgb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StWaitLock;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      fetch_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      hs0_q         <= 1'b0;
      vs0_q         <= 1'b0;
      de1_q         <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      de2_q         <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      rgb_q         <= '0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fetch_valid_q <= scan && h_act && v_act;
      frame_start_q <= scan && (h_cnt_q == '0) && (v_cnt_q == '0);
      fetch_x_q     <= scan ? h_cnt_q[XW-1:0] : '0;
      fetch_y_q     <= scan ? v_cnt_q[YW-1:0] : '0;
      hs0_q         <= scan && h_sync_win;
      vs0_q         <= scan && v_sync_win;
      de1_q         <= scan && fetch_valid_q;
      hs1_q         <= scan && hs0_q;
      vs1_q         <= scan && vs0_q;
      de2_q         <= scan && de1_q;
      hs2_q         <= scan && hs1_q;
      vs2_q         <= scan && vs1_q;
      // pixel_data belongs to the fetch now in stage 1.
      rgb_q         <= (scan && de1_q) ? bus.pixel_data : '0;
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_x     = fetch_x_q;
  assign bus.fetch_y     = fetch_y_q;
  assign bus.lcd_de      = de2_q;
  assign bus.lcd_hsync   = hs2_q ^ SYNC_ACTIVE_LOW;
  assign bus.lcd_vsync   = vs2_q ^ SYNC_ACTIVE_LOW;
  assign bus.lcd_rgb     = rgb_q;
  assign frame_start     = frame_start_q;
  assign running         = in_run;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench for lcd_timing: default horizontal timing, short vertical timing.
module tb_lcd_timing;
  localparam int unsigned HA = 480, HF = 8, HS = 4, HB = 43;
  localparam int unsigned HT = HA + HF + HS + HB;  // 535
  localparam int unsigned VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int unsigned VT = VA + VF + VS + VB;  // 31

  logic clock = 1'b0;
  logic reset_n, locked, frame_start, running;
  int   checks = 0;
  int   errors = 0;

  lcd_timing_if #(.H_ACTIVE(HA), .V_ACTIVE(VA), .RGB_W(16)) bus ();

  lcd_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1), .SETTLE_CYCLES(16), .RGB_W(16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .locked     (locked),
    .bus        (bus),
    .frame_start(frame_start),
    .running    (running)
  );

  always #5 clock = ~clock;

  // Frame source: answers each fetch one cycle later with {y, x}; junk when idle.
  always @(posedge clock)
    bus.pixel_data <= bus.fetch_valid ? {8'(bus.fetch_y), bus.fetch_x[7:0]} : 16'hbeef;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_de"},     32'(bus.lcd_de), 32'd0);
    chk({tag, "_hsync"},  32'(bus.lcd_hsync), 32'd1);
    chk({tag, "_vsync"},  32'(bus.lcd_vsync), 32'd1);
    chk({tag, "_rgb"},    32'(bus.lcd_rgb), 32'd0);
    chk({tag, "_fvalid"}, 32'(bus.fetch_valid), 32'd0);
    chk({tag, "_fstart"}, 32'(frame_start), 32'd0);
    chk({tag, "_run"},    32'(running), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned h, v, de_cnt, hs_low, vs_low;
    logic [31:0] exp_px, obs_px;
    bit found;

    reset_n = 1'b0;
    locked  = 1'b0;
    tick(3);
    chk_idle("reset");

    // Lock present from reset release: running 2+16 cycles later.
    reset_n = 1'b1;
    locked  = 1'b1;
    tick(17);
    chk("run_e17", 32'(running), 32'd0);
    tick(1);
    chk("run_e18", 32'(running), 32'd1);
    chk("fstart_e18", 32'(frame_start), 32'd0);
    tick(1);
    chk("fstart_e19", 32'(frame_start), 32'd1);
    chk("fvalid_e19", 32'(bus.fetch_valid), 32'd1);
    chk("fxy_e19", {16'(bus.fetch_y), 16'(bus.fetch_x)}, 32'd0);
    chk("de_e19", 32'(bus.lcd_de), 32'd0);
    tick(1);
    chk("fstart_e20", 32'(frame_start), 32'd0);
    chk("de_e20", 32'(bus.lcd_de), 32'd0);
    chk("fx_e20", 32'(bus.fetch_x), 32'd1);

    // One full frame on the panel pins, starting with the first de cycle.
    de_cnt = 0;
    hs_low = 0;
    vs_low = 0;
    for (int k = 0; k < int'(HT * VT); k++) begin
      tick(1);
      h = k % HT;
      v = k / HT;
      exp_px = '0;
      exp_px[18] = (h < HA) && (v < VA);
      exp_px[17] = !((h >= HA + HF) && (h < HA + HF + HS));
      exp_px[16] = !((v >= VA + VF) && (v < VA + VF + VS));
      if (exp_px[18]) exp_px[15:0] = {v[7:0], h[7:0]};
      obs_px = {13'd0, bus.lcd_de, bus.lcd_hsync, bus.lcd_vsync, bus.lcd_rgb};
      chk($sformatf("frame_px_v%0d_h%0d", v, h), obs_px, exp_px);
      if (bus.lcd_de)     de_cnt++;
      if (!bus.lcd_hsync) hs_low++;
      if (!bus.lcd_vsync) vs_low++;
    end
    chk("frame_de_total", de_cnt, HA * VA);
    chk("frame_hsync_low", hs_low, HS * VT);
    chk("frame_vsync_low", vs_low, VS * HT);

    // Lock loss mid-frame at line 20, pixel 200.
    found = 1'b0;
    for (int i = 0; i < int'(2 * HT * VT) && !found; i++) begin
      tick(1);
      if (bus.fetch_valid && bus.fetch_x == 9'd200 && bus.fetch_y == 5'd20) found = 1'b1;
    end
    chk("drop_point_reached", 32'(found), 32'd1);
    locked = 1'b0;
    tick(2);
    chk("drop_e2_run", 32'(running), 32'd1);
    chk("drop_e2_de", 32'(bus.lcd_de), 32'd1);
    tick(1);
    chk_idle("drop_e3");
    tick(5);
    chk("drop_idle_run", 32'(running), 32'd0);

    // Relock restarts the frame at 0,0.
    locked = 1'b1;
    tick(17);
    chk("relock_e17", 32'(running), 32'd0);
    tick(1);
    chk("relock_e18", 32'(running), 32'd1);
    tick(1);
    chk("relock_fstart", 32'(frame_start), 32'd1);
    chk("relock_fxy", {16'(bus.fetch_y), 16'(bus.fetch_x)}, 32'd0);
    tick(100);
    chk("relock_de98", 32'(bus.lcd_de), 32'd1);
    chk("relock_rgb98", 32'(bus.lcd_rgb), 32'h0062);

    // Asynchronous reset mid-line.
    #3;
    reset_n = 1'b0;
    #1;
    chk_idle("midreset");
    tick(1);
    reset_n = 1'b1;

    // Lock glitch while settling at count 10.
    tick(12);
    chk("glitch_pre_run", 32'(running), 32'd0);
    locked = 1'b0;
    tick(1);
    locked = 1'b1;
    tick(5);
    chk("glitch_e18_run", 32'(running), 32'd0);
    tick(12);
    chk("glitch_e30_run", 32'(running), 32'd0);
    tick(1);
    chk("glitch_e31_run", 32'(running), 32'd1);
    tick(1);
    chk("glitch_fstart", 32'(frame_start), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
